kyogenrv_dmem_responder: RTL and testbench



---
 rtl/kyogenrv_dmem_responder_pkg.sv | 23 ++
 rtl/kyogenrv_dmem_responder_if.sv | 26 ++
 rtl/kyogenrv_dmem_responder_bram.sv | 27 ++
 rtl/kyogenrv_dmem_responder.sv | 131 +++++++++++++
 tb/tb_kyogenrv_dmem_responder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/kyogenrv_dmem_responder_pkg.sv
// Shared types and helpers for the KyogenRV data-memory responder.
// Holds the responder FSM state type, bus widths and the address window check.
package kyogenrv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } resp_state_t;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = 4;

    // The sum is widened to 33 bits so a window ending at 4 GiB does not wrap.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned depth);
        logic [32:0] lim;
        lim = {1'b0, base} + (33'(depth) * 33'd4);
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < lim);
    endfunction

endpackage

// File: rtl/kyogenrv_dmem_responder_if.sv
// KyogenRV data-memory bus: request/waitrequest handshake plus read return.
interface kyogenrv_dmem_responder_if;
    import kyogenrv_mem_pkg::*;

    logic                r_dmem_data_req;
    logic                w_dmem_data_req;
    logic [31:0]         dmem_addr;
    logic [WORD_W-1:0]   w_dmem_data;
    logic [LANES-1:0]    w_dmem_data_byteenable;
    logic                dmem_waitrequest;
    logic                r_dmem_data_ack;
    logic [WORD_W-1:0]   r_dmem_data;

    modport master (
        output r_dmem_data_req, w_dmem_data_req, dmem_addr,
               w_dmem_data, w_dmem_data_byteenable,
        input  dmem_waitrequest, r_dmem_data_ack, r_dmem_data
    );

    modport slave (
        input  r_dmem_data_req, w_dmem_data_req, dmem_addr,
               w_dmem_data, w_dmem_data_byteenable,
        output dmem_waitrequest, r_dmem_data_ack, r_dmem_data
    );

endinterface

// File: rtl/kyogenrv_dmem_responder_bram.sv
// Single-port word RAM with per-byte-lane write enables and a registered read.
// Read returns the old word when the same address is written in the same cycle.
module kyogenrv_bram_be
    import kyogenrv_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [LANES-1:0]  be,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < LANES; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/kyogenrv_dmem_responder.sv
// Target end of the KyogenRV dmem bus: captures a request, stalls it for
// WAIT_STATES cycles, then performs a byte-enabled write or a one-cycle-ack read.
module kyogenrv_dmem_responder
    import kyogenrv_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_8000,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                      clock,
    input  logic                      reset,
    kyogenrv_dmem_responder_if.slave  bus,
    output logic [7:0]                err_count
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [3:0]  WS4 = 4'(WAIT_STATES);

    resp_state_t       state, state_nx;
    logic [3:0]        wait_cnt;
    logic              cap_write, cap_conflict;
    logic [31:0]       cap_addr;
    logic [WORD_W-1:0] cap_wdata;
    logic [LANES-1:0]  cap_be;
    logic [WORD_W-1:0] rd_hold;
    logic [WORD_W-1:0] rd_out;
    logic              ack;
    logic              req;
    logic              cap_ok;
    logic [AW-1:0]     ram_addr;
    logic [LANES-1:0]  ram_be;
    logic [WORD_W-1:0] ram_q;

    assign req    = bus.r_dmem_data_req | bus.w_dmem_data_req;
    assign cap_ok = in_range(cap_addr, BASE_ADDR, DEPTH);

    assign bus.dmem_waitrequest = req && (state != ACCESS);
    assign bus.r_dmem_data_ack  = ack;
    assign bus.r_dmem_data      = rd_out;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The RAM is addressed from the live bus in IDLE so that with no wait
    // states the registered read still lands in the following ACCESS cycle.
    always_comb begin
        state_nx = state;
        ram_addr = cap_addr[AW+1:2];
        ram_be   = '0;
        rd_out   = rd_hold;
        ack      = 1'b0;
        case (state)
            IDLE: begin
                ram_addr = bus.dmem_addr[AW+1:2];
                if (req) begin
                    state_nx = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nx = IDLE;
                end else if (wait_cnt <= 4'd1) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                state_nx = IDLE;
                if (cap_write) begin
                    if (cap_ok) begin
                        ram_be = cap_be;
                    end
                end else begin
                    ack    = 1'b1;
                    rd_out = cap_ok ? ram_q : ERR_DATA;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt     <= '0;
            cap_write    <= 1'b0;
            cap_conflict <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_be       <= '0;
            rd_hold      <= '0;
            err_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_write    <= bus.w_dmem_data_req;
                        cap_conflict <= bus.r_dmem_data_req & bus.w_dmem_data_req;
                        cap_addr     <= bus.dmem_addr;
                        cap_wdata    <= bus.w_dmem_data;
                        cap_be       <= bus.w_dmem_data_byteenable;
                        wait_cnt     <= WS4;
                    end
                end
                WAIT: wait_cnt <= wait_cnt - 4'd1;
                ACCESS: begin
                    if (!cap_write) begin
                        rd_hold <= rd_out;
                    end
                    if ((!cap_ok || cap_conflict) && (err_count != 8'hFF)) begin
                        err_count <= err_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    kyogenrv_bram_be #(.DEPTH(DEPTH)) u_ram (
        .clock (clock),
        .addr  (ram_addr),
        .wdata (cap_wdata),
        .be    (ram_be),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_kyogenrv_dmem_responder.sv
// Directed bench for kyogenrv_dmem_responder: a vector table on a 2-wait-state
// instance plus hand sequences for abort, reset and zero-wait back-to-back reads.
module tb_kyogenrv_dmem_responder;

    logic       clock;
    logic       reset_ws2, reset_ws0;
    logic [7:0] err_ws2, err_ws0;
    int         n_cmp = 0;
    int         n_bad = 0;

    kyogenrv_dmem_responder_if b2 ();
    kyogenrv_dmem_responder_if b0 ();

    kyogenrv_dmem_responder #(.WAIT_STATES(2)) dut2 (
        .clock     (clock),
        .reset     (reset_ws2),
        .bus       (b2),
        .err_count (err_ws2)
    );

    kyogenrv_dmem_responder #(.WAIT_STATES(0)) dut0 (
        .clock     (clock),
        .reset     (reset_ws0),
        .bus       (b0),
        .err_count (err_ws0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        exp_ack;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        if (sel) begin
            b0.r_dmem_data_req = rd; b0.w_dmem_data_req = wr; b0.dmem_addr = a;
            b0.w_dmem_data = d; b0.w_dmem_data_byteenable = be;
        end else begin
            b2.r_dmem_data_req = rd; b2.w_dmem_data_req = wr; b2.dmem_addr = a;
            b2.w_dmem_data = d; b2.w_dmem_data_byteenable = be;
        end
    endtask

    function automatic logic wr_of(input bit sel);
        return sel ? b0.dmem_waitrequest : b2.dmem_waitrequest;
    endfunction
    function automatic logic ack_of(input bit sel);
        return sel ? b0.r_dmem_data_ack : b2.r_dmem_data_ack;
    endfunction
    function automatic logic [31:0] rdata_of(input bit sel);
        return sel ? b0.r_dmem_data : b2.r_dmem_data;
    endfunction
    function automatic logic [7:0] err_of(input bit sel);
        return sel ? err_ws0 : err_ws2;
    endfunction

    // sel=0 targets the 2-wait-state instance, sel=1 the zero-wait one.
    task automatic txn(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input int exp_wait, input logic exp_ack, input logic [31:0] exp_rd,
                       input logic [7:0] exp_err, input string nm);
        int cyc;
        bit done;
        @(negedge clock);
        drive(sel, rd, wr, a, d, be);
        cyc  = 0;
        done = 0;
        while (!done && cyc < 20) begin
            #1;
            if (!wr_of(sel)) begin
                done = 1;
            end else begin
                cyc++;
                @(negedge clock);
            end
        end
        check({nm, " wait cycles"}, 32'(cyc), 32'(exp_wait));
        check({nm, " ack"}, 32'(ack_of(sel)), 32'(exp_ack));
        check({nm, " rdata"}, rdata_of(sel), exp_rd);
        @(negedge clock);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check({nm, " ack drop"}, 32'(ack_of(sel)), 32'h0);
        check({nm, " err_count"}, 32'(err_of(sel)), 32'(exp_err));
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h8000, 32'h1111_1111, 4'hF, 1'b0, 32'h0000_0000, 8'd0};
        vecs[1]  = '{1'b0, 1'b1, 32'h8010, 32'h1234_5678, 4'hF, 1'b0, 32'h0000_0000, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 32'h8010, 32'h0,         4'h0, 1'b1, 32'h1234_5678, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 32'h8010, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h1234_5678, 8'd0};
        vecs[4]  = '{1'b1, 1'b0, 32'h8010, 32'h0,         4'h0, 1'b1, 32'h12BB_56DD, 8'd0};
        vecs[5]  = '{1'b1, 1'b0, 32'h7FFC, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, 8'd1};
        vecs[6]  = '{1'b0, 1'b1, 32'h9000, 32'h5555_5555, 4'hF, 1'b0, 32'hDEAD_BEEF, 8'd2};
        vecs[7]  = '{1'b1, 1'b0, 32'h8000, 32'h0,         4'h0, 1'b1, 32'h1111_1111, 8'd2};
        vecs[8]  = '{1'b0, 1'b1, 32'h8FFC, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h1111_1111, 8'd2};
        vecs[9]  = '{1'b1, 1'b0, 32'h8FFC, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D, 8'd2};
        vecs[10] = '{1'b1, 1'b1, 32'h8020, 32'h0000_00FF, 4'hF, 1'b0, 32'hCAFE_F00D, 8'd3};
        vecs[11] = '{1'b1, 1'b0, 32'h8020, 32'h0,         4'h0, 1'b1, 32'h0000_00FF, 8'd3};
        vecs[12] = '{1'b0, 1'b1, 32'h8010, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0000_00FF, 8'd3};
        vecs[13] = '{1'b1, 1'b0, 32'h8010, 32'h0,         4'h0, 1'b1, 32'h12BB_56DD, 8'd3};

        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        reset_ws2 = 1'b1;
        reset_ws0 = 1'b1;
        #1;
        check("reset ack", 32'(b2.r_dmem_data_ack), 32'h0);
        check("reset rdata", b2.r_dmem_data, 32'h0);
        check("reset err", 32'(err_ws2), 32'h0);
        check("reset waitreq", 32'(b2.dmem_waitrequest), 32'h0);
        check("reset ws0 rdata", b0.r_dmem_data, 32'h0);
        @(negedge clock);
        reset_ws2 = 1'b0;
        reset_ws0 = 1'b0;

        for (int i = 0; i < 14; i++) begin
            txn(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be,
                3, vecs[i].exp_ack, vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("v%0d", i));
        end

        // Abort: read dropped in its first WAIT cycle must never complete.
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 32'h8010, 32'h0, 4'h0);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("abort ack c%0d", k + 1), 32'(b2.r_dmem_data_ack), 32'h0);
            check($sformatf("abort waitreq c%0d", k + 1), 32'(b2.dmem_waitrequest), 32'h0);
            @(negedge clock);
        end
        txn(1'b0, 1'b1, 1'b0, 32'h8010, 32'h0, 4'h0, 3, 1'b1, 32'h12BB_56DD, 8'd3, "post-abort");

        // Zero wait states: seed two words, then two reads with req held high.
        txn(1'b1, 1'b0, 1'b1, 32'h8004, 32'h0BAD_F00D, 4'hF, 1, 1'b0, 32'h0, 8'd0, "ws0 w1");
        txn(1'b1, 1'b0, 1'b1, 32'h8008, 32'h600D_CAFE, 4'hF, 1, 1'b0, 32'h0, 8'd0, "ws0 w2");
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b0, 32'h8004, 32'h0, 4'h0);
        #1;
        check("b2b c0 waitreq", 32'(b0.dmem_waitrequest), 32'h1);
        check("b2b c0 ack", 32'(b0.r_dmem_data_ack), 32'h0);
        @(negedge clock);
        #1;
        check("b2b c1 waitreq", 32'(b0.dmem_waitrequest), 32'h0);
        check("b2b c1 ack", 32'(b0.r_dmem_data_ack), 32'h1);
        check("b2b c1 rdata", b0.r_dmem_data, 32'h0BAD_F00D);
        drive(1'b1, 1'b1, 1'b0, 32'h8008, 32'h0, 4'h0);
        @(negedge clock);
        #1;
        check("b2b c2 waitreq", 32'(b0.dmem_waitrequest), 32'h1);
        check("b2b c2 ack", 32'(b0.r_dmem_data_ack), 32'h0);
        @(negedge clock);
        #1;
        check("b2b c3 waitreq", 32'(b0.dmem_waitrequest), 32'h0);
        check("b2b c3 ack", 32'(b0.r_dmem_data_ack), 32'h1);
        check("b2b c3 rdata", b0.r_dmem_data, 32'h600D_CAFE);
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("b2b hold ack", 32'(b0.r_dmem_data_ack), 32'h0);
        check("b2b hold rdata", b0.r_dmem_data, 32'h600D_CAFE);

        // Reset asserted while a read sits in WAIT clears outputs without a clock edge.
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 32'h7FFC, 32'h0, 4'h0);
        @(negedge clock);
        reset_ws2 = 1'b1;
        #1;
        check("rst-wait ack", 32'(b2.r_dmem_data_ack), 32'h0);
        check("rst-wait err", 32'(err_ws2), 32'h0);
        check("rst-wait rdata", b2.r_dmem_data, 32'h0);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        reset_ws2 = 1'b0;
        @(negedge clock);
        #1;
        check("post-rst ack", 32'(b2.r_dmem_data_ack), 32'h0);
        check("post-rst err", 32'(err_ws2), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
